// File: rtl/seg_pkg.sv
// Shared 7-segment display definitions used by the processor top
// and the digit scan multiplexer.
package seg_pkg;

  localparam int SEG_W_DEF  = 7;
  localparam int DIGITS_DEF = 5;
  localparam int SEG_W_MAX  = 16;
  localparam int BUS_MAX    = 128;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit k of a {dN,...,d0} bus of w-bit patterns; caller truncates.
  function automatic logic [SEG_W_MAX-1:0] seg_digit(
    input logic [BUS_MAX-1:0] bus,
    input int unsigned        k,
    input int unsigned        w
  );
    logic [BUS_MAX-1:0] sh;
    sh = bus >> (k * w);
    return sh[SEG_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/seg_scan_mux_divider.sv
// Slot timer for the digit scan: cnt within a slot, idx of the
// active digit, plus frame-start and anti-ghost blank strobes.
module scan_divider
  import seg_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DIV    = 50000,
  parameter int BLANK  = 4,
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          frame_start,
  output logic          in_blank
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign idx         = idx_q;
  assign frame_start = en && (cnt_q == '0) && (idx_q == '0);
  assign in_blank    = !en || (cnt_q < CNT_LIT);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes DIGITS segment patterns onto one shared bus,
// snapshotting the inputs once per frame so digits never tear.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int SEG_W  = SEG_W_DEF,
  parameter int DIV    = 50000,
  parameter int BLANK  = 4,
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [DIGITS*SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0]        seg_out,
  output logic [DIGITS-1:0]       dig_en,
  output logic                    frame_tick
);

  localparam logic [SEG_W-1:0] SEG_OFF = '1;

  logic [IW-1:0] idx;
  logic          frame_start;
  logic          in_blank;

  logic [DIGITS*SEG_W-1:0] snap_q, snap_d;
  logic [SEG_W-1:0]        seg_out_q, seg_out_d;
  logic [DIGITS-1:0]       dig_en_q, dig_en_d;
  logic                    frame_tick_q, frame_tick_d;

  scan_divider #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .idx         (idx),
    .frame_start (frame_start),
    .in_blank    (in_blank)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q       <= '1;
      seg_out_q    <= SEG_OFF;
      dig_en_q     <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      seg_out_q    <= seg_out_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Outputs use the pre-load snapshot; frame start is always blanked.
  always_comb begin
    snap_d       = frame_start ? seg_in : snap_q;
    frame_tick_d = frame_start;
    seg_out_d    = SEG_OFF;
    dig_en_d     = '1;
    if (!in_blank) begin
      dig_en_d  = ~(DIGITS'(1) << idx);
      seg_out_d = SEG_W'(seg_digit(BUS_MAX'(snap_q), 32'(idx), SEG_W));
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed + randomized bench for seg_scan_mux against a
// frame-position reference model.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int ND  = 5;
  localparam int SW  = 7;
  localparam int DV  = 8;
  localparam int BL  = 2;
  localparam int FRM = ND * DV;

  logic            clk;
  logic            reset;
  logic            en;
  logic [ND*SW-1:0] seg_in;
  logic [SW-1:0]   seg_out;
  logic [ND-1:0]   dig_en;
  logic            frame_tick;

  seg_scan_mux #(
    .DIGITS (ND),
    .SEG_W  (SW),
    .DIV    (DV),
    .BLANK  (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: enabled cycles since reset + frame snapshot
  int              e;
  logic [ND*SW-1:0] msnap;
  logic [SW-1:0]   exp_seg;
  logic [ND-1:0]   exp_dig;
  logic            exp_tick;

  int   c;
  int   last_tick;
  int   tick_gap;
  int   ones_run;
  logic have_lit;
  logic [ND-1:0] last_lit;
  int   off_left;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)",
             tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    e        = 0;
    msnap    = '1;
    exp_seg  = SEG_BLANK;
    exp_dig  = '1;
    exp_tick = 1'b0;
  endtask

  task automatic model_edge();
    int p, slot, off;
    if (!reset) begin
      model_reset();
    end else begin
      p    = e % FRM;
      slot = p / DV;
      off  = p % DV;
      if (!en || off < BL) begin
        exp_seg = SEG_BLANK;
        exp_dig = '1;
      end else begin
        exp_dig = ~(ND'(1) << slot);
        exp_seg = msnap[slot*SW +: SW];
      end
      exp_tick = en && (p == 0);
      if (en) begin
        if (p == 0) msnap = seg_in;
        e++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    c++;
    chk("seg_out", 64'(seg_out), 64'(exp_seg));
    chk("dig_en", 64'(dig_en), 64'(exp_dig));
    chk("frame_tick", 64'(frame_tick), 64'(exp_tick));
    chk("onehot", 64'($countones(~dig_en) <= 1), 64'(1));
    if (dig_en === '1) begin
      chk("blank_seg", 64'(seg_out), 64'(SEG_BLANK));
      ones_run++;
    end else begin
      if (have_lit && dig_en !== last_lit)
        chk("gap", 64'(ones_run >= 2), 64'(1));
      last_lit = dig_en;
      have_lit = 1'b1;
      ones_run = 0;
    end
    if (frame_tick === 1'b1) begin
      tick_gap  = c - last_tick;
      last_tick = c;
    end
  endtask

  task automatic run_to(input int n);
    while (c < n) cyc();
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    seg_in    = {7'h12, 7'h4F, 7'h24, 7'h30, 7'h79};
    c         = 0;
    last_tick = 0;
    tick_gap  = 0;
    ones_run  = 0;
    have_lit  = 1'b0;
    last_lit  = '1;
    off_left  = 0;
    model_reset();
    #10 reset = 1'b0;
    #1;
    chk("rst_seg", 64'(seg_out), 64'(7'h7F));
    chk("rst_dig", 64'(dig_en), 64'(5'h1F));
    chk("rst_tick", 64'(frame_tick), 64'(0));
    repeat (3) cyc();

    // run until digits are lit, then assert reset mid-cycle
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    repeat (5) cyc();
    chk("pre_async_dig", 64'(dig_en), 64'(5'h1E));
    #40 reset = 1'b0;
    #1;
    chk("async_seg", 64'(seg_out), 64'(7'h7F));
    chk("async_dig", 64'(dig_en), 64'(5'h1F));
    chk("async_tick", 64'(frame_tick), 64'(0));
    model_reset();

    @(negedge clk);
    reset     = 1'b1;
    c         = 0;
    last_tick = 0;
    cyc();
    chk("tick_c1", 64'(frame_tick), 64'(1));
    chk("blank_c1", 64'(dig_en), 64'(5'h1F));
    run_to(2);
    chk("blank_c2", 64'(dig_en), 64'(5'h1F));
    run_to(3);
    chk("d0_dig", 64'(dig_en), 64'(5'h1E));
    chk("d0_seg", 64'(seg_out), 64'(7'h79));
    run_to(9);
    chk("blank_c9", 64'(dig_en), 64'(5'h1F));
    run_to(11);
    chk("d1_dig", 64'(dig_en), 64'(5'h1D));
    chk("d1_seg", 64'(seg_out), 64'(7'h30));
    run_to(35);
    chk("d4_dig", 64'(dig_en), 64'(5'h0F));
    chk("d4_seg", 64'(seg_out), 64'(7'h12));
    run_to(41);
    chk("tick_c41", 64'(frame_tick), 64'(1));
    chk("period_40", 64'(tick_gap), 64'(40));
    run_to(43);
    chk("f2_d0_seg", 64'(seg_out), 64'(7'h79));

    // change digit 0 during the digit-2 slot of frame 2
    run_to(58);
    seg_in[6:0] = 7'h40;
    run_to(59);
    chk("f2_d2_seg", 64'(seg_out), 64'(7'h24));
    run_to(81);
    chk("tick_c81", 64'(frame_tick), 64'(1));
    run_to(83);
    chk("f3_d0_new", 64'(seg_out), 64'(7'h40));

    // pause 5 cycles inside the digit-1 lit window of frame 3
    run_to(92);
    chk("f3_d1_lit", 64'(dig_en), 64'(5'h1D));
    en = 1'b0;
    cyc();
    chk("pause_blank", 64'(dig_en), 64'(5'h1F));
    run_to(97);
    en = 1'b1;
    cyc();
    chk("resume_d1", 64'(dig_en), 64'(5'h1D));
    run_to(126);
    chk("tick_c126", 64'(frame_tick), 64'(1));
    chk("period_45", 64'(tick_gap), 64'(45));

    // randomized patterns and pauses over several frames
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0)
        seg_in = 35'({$urandom(), $urandom()});
      if (off_left > 0) begin
        off_left--;
        if (off_left == 0) en = 1'b1;
      end else if ($urandom_range(0, 29) == 0) begin
        en       = 1'b0;
        off_left = $urandom_range(1, 6);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Downstream display stage for the 8-bit microprocessor top (Main). Main drives five 7-segment digit patterns out1..out5 continuously. This block time-multiplexes them onto the board's single shared segment bus with one-hot digit enables. It snapshots all five patterns at each frame start, so a digit never shows a value that changed partway through a frame. Its refresh counter runs off the same clk as the processor.

Parameters:
DIGITS, 5, number of multiplexed digits (index 0 = out1)
SEG_W, 7, segment pattern width
DIV, 50000, clk cycles per digit slot (must be > BLANK)
BLANK, 4, cycles at start of each slot with all digits off for anti-ghosting (must be >= 1)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
en  in  1  scan enable; 0 pauses the scan and blanks the display
seg_in  in  DIGITS*SEG_W  concatenated patterns {out5,...,out1}, active-low segments, passed through unmodified
seg_out  out  SEG_W  shared segment bus, active-low
dig_en  out  DIGITS  digit enables, active-low one-hot
frame_tick  out  1  one-cycle pulse at each frame start (snapshot load)

Behaviour:
- Reset (reset=0, asynchronous): cnt=0, idx=0, snapshot = all 1s, seg_out=7'h7F, dig_en all 1s, frame_tick=0.
- State:
  - cnt counts 0..DIV-1.
  - idx counts 0..DIGITS-1.
  - snap holds DIGITS*SEG_W bits.
- Advance: each enabled cycle, cnt increments. At cnt==DIV-1, cnt wraps to 0 and idx advances. idx wraps from DIGITS-1 to 0.
- Frame start is the enabled cycle with cnt==0 && idx==0. On that cycle's edge:
  - snap <= seg_in.
  - frame_tick=1 for exactly the following cycle.
- Because frame start is cnt==0, the first enabled cycle after reset release is a frame start, and the first frame shows the current seg_in.
- Outputs are registered and computed from the current state (cnt, idx, snap), so they lag state by one cycle:
  - if !en or cnt<BLANK: dig_en <= all 1s, seg_out <= 7'h7F.
  - else: dig_en <= ~(1<<idx), seg_out <= snap[idx*SEG_W +: SEG_W].
- Since BLANK>=1, the snapshot is always loaded before digit 0 is lit.
- Frame length = DIGITS*DIV cycles. frame_tick period = DIGITS*DIV enabled cycles.
- en=0:
  - cnt, idx and snap hold.
  - Next cycle: dig_en all 1s, seg_out blank, no frame_tick.
  - When en returns, the scan resumes from the held cnt/idx; it does not restart the frame.
- seg_in changes between frame starts have no visible effect until the next frame start.
- At no cycle is more than one dig_en bit low. Every slot change passes through all-off cycles.
- Reset asserted mid-frame: outputs are forced blank immediately (asynchronous). After release, the scan restarts at idx 0.
- Widths: cnt = $clog2(DIV), idx = $clog2(DIGITS). There are no unused idx codes in the active path; idx is never >= DIGITS.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'h7F
  - default DIGITS/SEG_W
  - a function that extracts digit k from the concatenated bus.
  Main and this block both import the package.
- One natural sub-module, scan_divider, owns cnt/idx, the wrap logic, the en hold, and generates the frame_start and in_blank strobes. seg_scan_mux owns snap and the output registers.

Test Plan:
Bench parameters: DIGITS=5, SEG_W=7, DIV=8, BLANK=2, clk period 100.
1. reset=0 held -> seg_out=7'h7F, dig_en=5'b11111, frame_tick=0. Assert reset mid-clock -> same values immediately, without waiting for a clk edge.
2. seg_in={7'h12,7'h4F,7'h24,7'h30,7'h79}, en=1, release reset -> frame_tick=1 in cycle 1.
   - Cycles 1-2: dig_en=11111.
   - Cycles 3-8: dig_en=11110, seg_out=7'h79.
   - Cycles 9-10: blank.
   - Cycles 11-16: dig_en=11101, seg_out=7'h30.
   - Pattern continues through digit 4 (seg_out=7'h12). frame_tick recurs every 40 cycles.
3. Change seg_in digit 0 to 7'h40 during digit-2 slot -> current frame keeps 7'h79. After the next frame_tick, digit 0 shows 7'h40.
4. Drop en for 5 cycles in the middle of the digit-1 lit window -> dig_en=11111 from the next cycle. On re-enable, digit 1 finishes its remaining lit cycles, and the frame_tick period extends by exactly 5.
5. Run 3 full frames with a checker on every cycle:
   - dig_en always has at most one 0.
   - At least 2 all-ones cycles occur between different one-hot values.
   - seg_out=7'h7F whenever dig_en=11111.
